// File: rtl/shift_left_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_left_seq_pkg
// Description : Shared width defaults and FSM state encoding for the
//               sequential logical left shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_left_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    // 2'd3 is unused; any stray value is decoded as IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shift_left_seq_pkg
`default_nettype wire

// File: rtl/shift_left_seq_shl1_row.sv
`default_nettype none
// ============================================================================
// Module      : shl1_row
// Description : One row of 2:1 mux cells; shifts left by one when sel=1,
//               passes the input through otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module shl1_row
    import shift_left_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout[0] = sel ? 1'b0 : din[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_mux
        assign dout[i] = sel ? din[i-1] : din[i];
    end

endmodule : shl1_row
`default_nettype wire

// File: rtl/shift_left_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_left_seq
// Description : Multi-cycle logical left shifter, one bit per clock, with a
//               start/busy/done handshake and a held result register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_left_seq
    import shift_left_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [SHW-1:0]   dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_shl;
    logic             shift_en;

    assign shift_en = (state == ST_SHIFT);

    shl1_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .sel  (shift_en),
        .din  (acc),
        .dout (acc_shl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            dataOut <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc <= dataA;
                        cnt <= dataB;
                        // Zero shift: result is available without any SHIFT cycle.
                        if (dataB == '0)
                            dataOut <= dataA;
                    end
                end
                ST_SHIFT: begin
                    acc <= acc_shl;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1))
                        dataOut <= acc_shl;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = ST_IDLE;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = (dataB == '0) ? ST_DONE : ST_SHIFT;
                else
                    state_nx = ST_IDLE;
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                state_nx = (cnt == SHW'(1)) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule : shift_left_seq
`default_nettype wire

// File: tb/tb_shift_left_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_left_seq
// Description : Self-checking bench: directed vector table, hand-written
//               multi-cycle sequences and randomized ops vs. a shift model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_left_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dataA;
    logic [4:0]  dataB;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    int          checks;
    int          errors;
    logic [31:0] prev_res;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    shift_left_seq #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic logical shift.
    function automatic logic [31:0] model_shl(input logic [31:0] a, input logic [4:0] b);
        logic [31:0] r;
        r = a << b;
        return r;
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge of the
    // first IDLE cycle after done, so consecutive calls run back-to-back.
    task automatic do_op(input logic [31:0] a, input logic [4:0] b,
                         input logic [31:0] exp_res, input string nm);
        int got;
        got   = -1;
        start = 1'b1;
        dataA = a;
        dataB = b;
        @(negedge clk);
        start = 1'b0;
        dataA = $urandom;
        dataB = 5'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                got = k;
                break;
            end
            if (busy !== 1'b1 || dataOut !== prev_res) begin
                chk({nm, " busy/hold"}, {busy, dataOut[30:0]}, {1'b1, prev_res[30:0]});
            end
            @(negedge clk);
        end
        chk({nm, " latency"}, 32'(got), 32'(b));
        chk({nm, " result"}, dataOut, exp_res);
        chk({nm, " busy@done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({nm, " idle busy/done"}, {30'd0, busy, done}, 32'd0);
        chk({nm, " result held"}, dataOut, exp_res);
        prev_res = exp_res;
    endtask

    initial begin
        int          got;
        int          ndone;
        logic [31:0] ra;
        logic [4:0]  rb;

        checks   = 0;
        errors   = 0;
        prev_res = 32'd0;
        rst      = 1'b1;
        start    = 1'b0;
        dataA    = 32'd0;
        dataB    = 5'd0;

        vecs[0] = '{32'h12345678, 5'd4,  32'h23456780};
        vecs[1] = '{32'h00000001, 5'd31, 32'h80000000};
        vecs[2] = '{32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF};
        vecs[3] = '{32'hF0000001, 5'd3,  32'h80000008};
        vecs[4] = '{32'h00000003, 5'd1,  32'h00000006};
        vecs[5] = '{32'h0000FFFF, 5'd8,  32'h00FFFF00};
        vecs[6] = '{32'h80000000, 5'd1,  32'h00000000};
        vecs[7] = '{32'hAAAAAAAA, 5'd16, 32'hAAAA0000};

        // Reset
        repeat (2) @(negedge clk);
        chk("reset dataOut", dataOut, 32'd0);
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, run back-to-back
        for (int i = 0; i < 8; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // start held high with inputs changing during SHIFT
        start = 1'b1;
        dataA = 32'hF0000001;
        dataB = 5'd3;
        got   = -1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                got = k;
                break;
            end
            dataA = $urandom;
            dataB = 5'($urandom_range(1, 31));
        end
        chk("held latency", 32'(got), 32'd3);
        chk("held result", dataOut, 32'h80000008);
        dataA = 32'h00000005;
        dataB = 5'd2;
        @(negedge clk);
        chk("held idle after done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("held second accepted", {31'd0, busy}, 32'd1);
        got = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                ndone++;
                got = k;
                break;
            end
            @(negedge clk);
        end
        chk("held second latency", 32'(got), 32'd2);
        chk("held second result", dataOut, 32'h00000014);
        chk("held done count", 32'(ndone), 32'd2);
        @(negedge clk);
        prev_res = 32'h00000014;

        // Reset aborts an in-flight op
        start = 1'b1;
        dataA = 32'hAAAAAAAA;
        dataB = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort in SHIFT", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy/done", {30'd0, busy, done}, 32'd0);
        chk("abort dataOut", dataOut, 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no done", 32'(ndone), 32'd0);
        prev_res = 32'd0;
        do_op(32'h00000003, 5'd1, 32'h00000006, "post-abort");

        // Back-to-back: second op starts in the first IDLE cycle
        do_op(32'h12345678, 5'd4, 32'h23456780, "b2b first");
        do_op(32'h0000FFFF, 5'd8, 32'h00FFFF00, "b2b second");

        // Randomized ops against the model
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = 5'($urandom);
            do_op(ra, rb, model_shl(ra, rb), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_left_seq
`default_nettype wire
